// File: rtl/lowspeed_cmd_engine_pkg.sv
// Shared definitions for the low-speed command engine:
// opcodes, FSM state encodings and error bit positions.
package lowspeed_cmd_engine_pkg;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_ARGS  = 5'b00010,
        ST_EXEC  = 5'b00100,
        ST_OUT   = 5'b01000,
        ST_PULSE = 5'b10000
    } state_e;

    localparam logic [7:0] OP_NOOP       = 8'h00;
    localparam logic [7:0] OP_ECHO1      = 8'h41;
    localparam logic [7:0] OP_ECHO2      = 8'h81;
    localparam logic [7:0] OP_ECHO3      = 8'hC1;
    localparam logic [7:0] OP_SET_LEDS   = 8'h44;
    localparam logic [7:0] OP_SOFT_RESET = 8'h05;
    localparam logic [7:0] OP_SET_PPU    = 8'h46;
    localparam logic [7:0] OP_STATUS     = 8'h07;
    localparam logic [7:0] OP_CLR_ERR    = 8'h08;
    localparam logic [7:0] OP_READ_EDGE  = 8'h49;
    localparam logic [7:0] OP_PULSE_XIN  = 8'h4A;

    localparam int ERR_BAD_ARG    = 3;
    localparam int ERR_BAD_STATE  = 2;
    localparam int ERR_BAD_OPCODE = 1;

endpackage

// File: rtl/lowspeed_edge_counter.sv
// One edge-counter channel: 2-flop synchroniser, rising-edge
// detect and a saturating counter with synchronous clear.
module lowspeed_edge_counter #(
    parameter int CW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          edge_i,
    input  logic          clr_i,
    output logic [CW-1:0] cnt_o
);

    logic [2:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          rise;

    assign rise  = sync_q[1] & ~sync_q[2];
    assign cnt_o = cnt_q;

    // Next count: clear beats an edge, counting stops at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (rise && !(&cnt_q))
            cnt_d = cnt_q + CW'(1);
    end

    // Synchroniser, edge history and counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[1:0], edge_i};
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/lowspeed_cmd_engine.sv
// Byte-stream command engine driving the SNES PPU low-speed pins:
// opcode/argument parser, executor, response shifter, XIN pulser.
module lowspeed_cmd_engine
    import lowspeed_cmd_engine_pkg::*;
#(
    parameter int NUM_LEDS    = 4,
    parameter int NUM_EDGE_CH = 4,
    parameter int CNT_BYTES   = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             read_data_i,
    input  logic                   read_valid_i,
    output logic                   read_ready_o,
    output logic [7:0]             write_data_o,
    output logic                   write_valid_o,
    input  logic                   write_ready_i,
    input  logic [NUM_EDGE_CH-1:0] edge_in,
    output logic                   xin,
    output logic                   ppu1_reset_n,
    output logic                   ppu2_reset_n,
    output logic [NUM_LEDS-1:0]    leds,
    output logic [3:0]             error_o
);

    localparam int CW = 8 * CNT_BYTES;

    state_e                state_q, state_d;
    logic [7:0]            op_q, op_d;
    logic [23:0]           args_q, args_d;
    logic [1:0]            argn_q, argn_d;
    logic [23:0]           out_q, out_d;
    logic [1:0]            outn_q, outn_d;
    logic [8:0]            pcnt_q, pcnt_d;
    logic                  xin_q, xin_d;
    logic [NUM_LEDS-1:0]   leds_q, leds_d;
    logic                  rst1_q, rst1_d;
    logic                  rst2_q, rst2_d;
    logic [3:0]            err_q, err_d;
    logic [3:0]            err_set;
    logic                  err_clr;
    logic                  cnt_clr;
    logic                  rd_fire, wr_fire;
    logic                  ch_ok;
    logic [CW-1:0]         snap;
    logic [NUM_EDGE_CH-1:0][CW-1:0] cnt_all;

    assign read_ready_o  = (state_q == ST_IDLE) || (state_q == ST_ARGS);
    assign write_valid_o = (state_q == ST_OUT);
    assign write_data_o  = out_q[7:0];
    assign rd_fire       = read_valid_i && read_ready_o;
    assign wr_fire       = write_valid_o && write_ready_i;
    assign xin           = xin_q;
    assign ppu1_reset_n  = rst1_q;
    assign ppu2_reset_n  = rst2_q;
    assign leds          = leds_q;
    assign error_o       = err_q;

    for (genvar g = 0; g < NUM_EDGE_CH; g++) begin : g_ch
        lowspeed_edge_counter #(.CW(CW)) u_cnt (
            .clock  (clock),
            .reset  (reset),
            .edge_i (edge_in[g]),
            .clr_i  (cnt_clr),
            .cnt_o  (cnt_all[g])
        );
    end

    // Select the counter named by the argument byte, flag out-of-range
    always_comb begin
        snap  = '0;
        ch_ok = 1'b0;
        for (int i = 0; i < NUM_EDGE_CH; i++) begin
            if (args_q[7:0] == 8'(i)) begin
                snap  = cnt_all[i];
                ch_ok = 1'b1;
            end
        end
    end

    // FSM next state, command execution and register updates
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        args_d  = args_q;
        argn_d  = argn_q;
        out_d   = out_q;
        outn_d  = outn_q;
        pcnt_d  = pcnt_q;
        xin_d   = xin_q;
        leds_d  = leds_q;
        rst1_d  = rst1_q;
        rst2_d  = rst2_q;
        err_set = 4'h0;
        err_clr = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd_fire) begin
                    op_d    = read_data_i;
                    argn_d  = read_data_i[7:6];
                    state_d = (read_data_i[7:6] == 2'd0) ? ST_EXEC : ST_ARGS;
                end
            end
            ST_ARGS: begin
                if (rd_fire) begin
                    args_d = {args_q[15:0], read_data_i};
                    argn_d = argn_q - 2'd1;
                    if (argn_q == 2'd1)
                        state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                case (op_q)
                    OP_NOOP: ;
                    OP_ECHO1: begin
                        out_d   = {16'h0, args_q[7:0]};
                        outn_d  = 2'd1;
                        state_d = ST_OUT;
                    end
                    OP_ECHO2: begin
                        out_d   = {8'h0, args_q[7:0], args_q[15:8]};
                        outn_d  = 2'd2;
                        state_d = ST_OUT;
                    end
                    OP_ECHO3: begin
                        out_d   = {args_q[7:0], args_q[15:8], args_q[23:16]};
                        outn_d  = 2'd3;
                        state_d = ST_OUT;
                    end
                    OP_SET_LEDS: leds_d = args_q[NUM_LEDS-1:0];
                    OP_SOFT_RESET: begin
                        leds_d  = '0;
                        rst1_d  = 1'b0;
                        rst2_d  = 1'b0;
                        xin_d   = 1'b0;
                        err_clr = 1'b1;
                        cnt_clr = 1'b1;
                    end
                    OP_SET_PPU: begin
                        rst1_d = args_q[0];
                        rst2_d = args_q[1];
                    end
                    OP_STATUS: begin
                        out_d   = {16'h0, rst2_q, rst1_q, 2'b00, err_q};
                        outn_d  = 2'd1;
                        state_d = ST_OUT;
                    end
                    OP_CLR_ERR: err_clr = 1'b1;
                    OP_READ_EDGE: begin
                        if (ch_ok) begin
                            out_d   = 24'(snap);
                            outn_d  = 2'(CNT_BYTES);
                            state_d = ST_OUT;
                        end else begin
                            err_set[ERR_BAD_ARG] = 1'b1;
                        end
                    end
                    OP_PULSE_XIN: begin
                        pcnt_d  = {args_q[7:0], 1'b1};
                        xin_d   = 1'b1;
                        state_d = ST_PULSE;
                    end
                    default: err_set[ERR_BAD_OPCODE] = 1'b1;
                endcase
            end
            ST_OUT: begin
                if (wr_fire) begin
                    out_d  = out_q >> 8;
                    outn_d = outn_q - 2'd1;
                    if (outn_q == 2'd1)
                        state_d = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (pcnt_q == 9'd0) begin
                    xin_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    pcnt_d = pcnt_q - 9'd1;
                    xin_d  = ~pcnt_q[0];
                end
            end
            default: begin
                err_set[ERR_BAD_STATE] = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
        err_d = ((err_clr ? 4'h0 : err_q) | err_set) & 4'b1110;
    end

    // State and control registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= 8'h0;
            args_q  <= 24'h0;
            argn_q  <= 2'd0;
            out_q   <= 24'h0;
            outn_q  <= 2'd0;
            pcnt_q  <= 9'd0;
            xin_q   <= 1'b0;
            leds_q  <= '0;
            rst1_q  <= 1'b0;
            rst2_q  <= 1'b0;
            err_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            args_q  <= args_d;
            argn_q  <= argn_d;
            out_q   <= out_d;
            outn_q  <= outn_d;
            pcnt_q  <= pcnt_d;
            xin_q   <= xin_d;
            leds_q  <= leds_d;
            rst1_q  <= rst1_d;
            rst2_q  <= rst2_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_lowspeed_cmd_engine.sv
// Directed bench for lowspeed_cmd_engine; a second instance with
// one-byte counters covers counter saturation in few cycles.
module tb_lowspeed_cmd_engine;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] read_data_i;
    logic       read_valid_i;
    logic       read_ready_o;
    logic [7:0] write_data_o;
    logic       write_valid_o;
    logic       write_ready_i;
    logic [3:0] edge_in;
    logic       xin;
    logic       ppu1_reset_n;
    logic       ppu2_reset_n;
    logic [3:0] leds;
    logic [3:0] error_o;

    logic       rr2;
    logic [7:0] wd2;
    logic       wv2;
    logic [3:0] edge2;
    logic       xin2;
    logic       p1_2;
    logic       p2_2;
    logic [3:0] leds2;
    logic [3:0] err2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    lowspeed_cmd_engine #(
        .NUM_LEDS(4), .NUM_EDGE_CH(4), .CNT_BYTES(2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .read_data_i   (read_data_i),
        .read_valid_i  (read_valid_i),
        .read_ready_o  (read_ready_o),
        .write_data_o  (write_data_o),
        .write_valid_o (write_valid_o),
        .write_ready_i (write_ready_i),
        .edge_in       (edge_in),
        .xin           (xin),
        .ppu1_reset_n  (ppu1_reset_n),
        .ppu2_reset_n  (ppu2_reset_n),
        .leds          (leds),
        .error_o       (error_o)
    );

    lowspeed_cmd_engine #(
        .NUM_LEDS(4), .NUM_EDGE_CH(4), .CNT_BYTES(1)
    ) dut_sat (
        .clock         (clock),
        .reset         (reset),
        .read_data_i   (read_data_i),
        .read_valid_i  (read_valid_i),
        .read_ready_o  (rr2),
        .write_data_o  (wd2),
        .write_valid_o (wv2),
        .write_ready_i (write_ready_i),
        .edge_in       (edge2),
        .xin           (xin2),
        .ppu1_reset_n  (p1_2),
        .ppu2_reset_n  (p2_2),
        .leds          (leds2),
        .error_o       (err2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after transfer
    task automatic send(input logic [7:0] b);
        int n = 0;
        read_data_i  = b;
        read_valid_i = 1'b1;
        while (read_ready_o !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) chk("send_timeout", 32'(n), 32'd0);
        @(negedge clock);
        read_valid_i = 1'b0;
    endtask

    // Holds ready low one cycle (data must stay put), then takes the byte
    task automatic recv(input string tag, input logic [7:0] exp);
        int n = 0;
        while (write_valid_o !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) chk({tag, "_timeout"}, 32'(n), 32'd0);
        chk(tag, 32'(write_data_o), 32'(exp));
        @(negedge clock);
        chk({tag, "_hold"}, 32'({write_valid_o, write_data_o}),
            32'({1'b1, exp}));
        write_ready_i = 1'b1;
        @(negedge clock);
        write_ready_i = 1'b0;
    endtask

    initial begin
        int lowc;
        int hi;
        int rises;
        int n;
        logic px;

        reset         = 1'b1;
        read_data_i   = 8'h0;
        read_valid_i  = 1'b0;
        write_ready_i = 1'b0;
        edge_in       = 4'h0;
        edge2         = 4'h0;
        repeat (3) @(negedge clock);
        chk("rst_ready", 32'(read_ready_o), 32'd1);
        chk("rst_wvalid", 32'(write_valid_o), 32'd0);
        chk("rst_xin", 32'(xin), 32'd0);
        chk("rst_ppu", 32'({ppu2_reset_n, ppu1_reset_n}), 32'd0);
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_err", 32'(error_o), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // 0-arg opcode: EXECUTE one cycle later, response the cycle after
        read_data_i  = 8'h07;
        read_valid_i = 1'b1;
        @(negedge clock);
        read_valid_i = 1'b0;
        chk("lat_exec", 32'({write_valid_o, read_ready_o}), 32'd0);
        @(negedge clock);
        chk("lat_out", 32'({write_valid_o, write_data_o}), 32'h100);
        write_ready_i = 1'b1;
        @(negedge clock);
        write_ready_i = 1'b0;
        chk("lat_idle", 32'({write_valid_o, read_ready_o}), 32'd1);

        send(8'h41); send(8'h5A);
        recv("echo1", 8'h5A);

        send(8'hC1); send(8'h11); send(8'h22); send(8'h33);
        recv("echo3_b0", 8'h11);
        recv("echo3_b1", 8'h22);
        recv("echo3_b2", 8'h33);
        chk("echo3_done", 32'(write_valid_o), 32'd0);

        send(8'h81); send(8'hA1); send(8'hB2);
        recv("echo2_b0", 8'hA1);
        recv("echo2_b1", 8'hB2);

        send(8'h44); send(8'h0F);
        @(negedge clock);
        chk("leds_set", 32'(leds), 32'hF);

        send(8'h46); send(8'h03);
        @(negedge clock);
        chk("ppu_set", 32'({ppu2_reset_n, ppu1_reset_n}), 32'd3);
        send(8'h07);
        recv("status_ppu", 8'hC0);

        send(8'h05);
        @(negedge clock);
        chk("soft_leds", 32'(leds), 32'd0);
        chk("soft_ppu", 32'({ppu2_reset_n, ppu1_reset_n}), 32'd0);

        // XIN burst: EXECUTE plus 6 PULSE cycles with ready low
        send(8'h4A); send(8'h02);
        lowc  = 0;
        hi    = 0;
        rises = 0;
        px    = 1'b0;
        while (read_ready_o !== 1'b1 && lowc < 100) begin
            if (xin === 1'b1) hi++;
            if (xin === 1'b1 && !px) rises++;
            px = xin;
            @(negedge clock);
            lowc++;
        end
        chk("pulse_busy_cycles", 32'(lowc), 32'd7);
        chk("pulse_high_cycles", 32'(hi), 32'd3);
        chk("pulse_rises", 32'(rises), 32'd3);
        chk("pulse_xin_end", 32'(xin), 32'd0);

        for (int i = 0; i < 5; i++) begin
            edge_in[1] = 1'b1;
            repeat (2) @(negedge clock);
            edge_in[1] = 1'b0;
            repeat (2) @(negedge clock);
        end
        for (int i = 0; i < 300; i++) begin
            edge2[0] = 1'b1;
            repeat (2) @(negedge clock);
            edge2[0] = 1'b0;
            repeat (2) @(negedge clock);
        end
        repeat (4) @(negedge clock);

        send(8'h49); send(8'h01);
        recv("edge1_lo", 8'h05);
        recv("edge1_hi", 8'h00);
        send(8'h49); send(8'h01);
        recv("edge1_again_lo", 8'h05);
        recv("edge1_again_hi", 8'h00);

        send(8'h49); send(8'h00);
        n = 0;
        while (write_valid_o !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("sat_one_byte", 32'({wv2, wd2}), 32'h1FF);
        recv("edge0_lo", 8'h00);
        recv("edge0_hi", 8'h00);

        send(8'h05);
        @(negedge clock);
        send(8'h49); send(8'h01);
        recv("edge_clr_lo", 8'h00);
        recv("edge_clr_hi", 8'h00);

        send(8'h3F);
        @(negedge clock);
        chk("badop_port", 32'(error_o), 32'h2);
        chk("badop_noout", 32'(write_valid_o), 32'd0);
        send(8'h07);
        recv("status_badop", 8'h02);
        send(8'h08);
        send(8'h07);
        recv("status_clr1", 8'h00);
        send(8'h49); send(8'h09);
        @(negedge clock);
        chk("badarg_noout", 32'({write_valid_o, read_ready_o}), 32'd1);
        send(8'h07);
        recv("status_badarg", 8'h08);
        send(8'h08);
        send(8'h07);
        recv("status_clr2", 8'h00);

        // Reset while C1 still waits for arguments
        send(8'h44); send(8'h05);
        send(8'hC1); send(8'h11);
        #2 reset = 1'b1;
        @(negedge clock);
        chk("rargs_ready", 32'({read_ready_o, write_valid_o}), 32'd2);
        chk("rargs_leds", 32'(leds), 32'd0);
        reset = 1'b0;
        send(8'h41); send(8'hAA);
        recv("rargs_echo", 8'hAA);

        // Reset while xin is high inside a burst
        send(8'h4A); send(8'h05);
        n = 0;
        while (xin !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("rpulse_seen_high", 32'(xin), 32'd1);
        #1 reset = 1'b1;
        #1 chk("rpulse_xin_now", 32'(xin), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        chk("rpulse_ready", 32'({read_ready_o, write_valid_o}), 32'd2);
        send(8'h41); send(8'hAA);
        recv("rpulse_echo", 8'hAA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
